// File: rtl/z8_timer.sv
// z8_timer: Z8 counter/timer block (T0/T1, prescalers PRE0/PRE1, mode register TMR)
// on the SFR bus at 0xF1-0xF5. Raises one-cycle IRQ4 (T0) / IRQ5 (T1) pulses.
// Optional feature macro: Z8_TIMER_TOUT_EN enables the TOUT toggle output;
// when undefined, tout is tied low and TMR[7:6] are plain storage.
module z8_timer #(
    parameter int DIV_LOG2 = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sfrAddr,
    input  logic       sfrWrite,
    input  logic [7:0] sfrDataIn,
    output logic [7:0] sfrDataOut,
    output logic       irqT0,
    output logic       irqT1,
    output logic       tout
);

    localparam logic [7:0] ADDR_TMR  = 8'hF1;
    localparam logic [7:0] ADDR_T1   = 8'hF2;
    localparam logic [7:0] ADDR_PRE1 = 8'hF3;
    localparam logic [7:0] ADDR_T0   = 8'hF4;
    localparam logic [7:0] ADDR_PRE0 = 8'hF5;

    // Index 0 is T0/PRE0, index 1 is T1/PRE1 throughout.
    logic [DIV_LOG2-1:0] div;
    logic                tick;
    logic [1:0]          tout_sel;    // TMR[7:6]
    logic [1:0]          tmr_spare;   // TMR[5:4], storage only
    logic [1:0]          en;          // TMR[3] / TMR[1]
    logic [7:0]          reload [2];  // Tn reload value
    logic [7:0]          pre    [2];  // PREn as written; [7:2] reload, [0] continuous
    logic [7:0]          cnt    [2];  // live counters
    logic [5:0]          ps     [2];  // live prescalers
    logic [1:0]          irq_q;
    logic                tmr_wr;
    logic [1:0]          load;
    logic [1:0]          step;
    logic [1:0]          eoc;

    assign tick   = &div;
    assign tmr_wr = sfrWrite && (sfrAddr == ADDR_TMR);
    assign irqT0  = irq_q[0];
    assign irqT1  = irq_q[1];

    // Free-running clock divider; tick is high on the last phase of each period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            div <= div + 1'b1;
        end
    end

    // Per-timer load strobes, counting qualifiers and end-of-count detection.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // held, which would infer a latch.
        load = '0;
        step = '0;
        eoc  = '0;
        for (int i = 0; i < 2; i++) begin
            load[i] = tmr_wr && sfrDataIn[2*i];
            // A load on the same edge overrides counting, so it also masks eoc.
            step[i] = tick && en[i] && !load[i];
            eoc[i]  = step[i] && (ps[i] == 6'd1) && (cnt[i] == 8'd1);
        end
    end

    // Host-writable registers: TMR upper bits and the Tn / PREn reload values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tout_sel  <= '0;
            tmr_spare <= '0;
            // NOTE: these arrays are a handful of flops, not a RAM macro, so
            // clearing them in the async reset branch is intended.
            for (int i = 0; i < 2; i++) begin
                reload[i] <= '0;
                pre[i]    <= '0;
            end
        end else if (sfrWrite) begin
            case (sfrAddr)
                ADDR_TMR: begin
                    tout_sel  <= sfrDataIn[7:6];
                    tmr_spare <= sfrDataIn[5:4];
                end
                ADDR_T1:   reload[1] <= sfrDataIn;
                ADDR_PRE1: pre[1]    <= sfrDataIn;
                ADDR_T0:   reload[0] <= sfrDataIn;
                ADDR_PRE0: pre[0]    <= sfrDataIn;
                default: ;
            endcase
        end
    end

    // Prescaler/counter datapath, enable bits and registered irq pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en    <= '0;
            irq_q <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
                ps[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (load[i]) begin
                    ps[i]  <= pre[i][7:2];
                    cnt[i] <= reload[i];
                end else if (step[i]) begin
                    if (ps[i] == 6'd1) begin
                        // Prescaler expired: reload it and step the counter.
                        // A reload of 0 wraps through 63/255, giving 64/256.
                        ps[i] <= pre[i][7:2];
                        if (cnt[i] == 8'd1)
                            cnt[i] <= pre[i][0] ? reload[i] : 8'd0;
                        else
                            cnt[i] <= cnt[i] - 8'd1;
                    end else begin
                        ps[i] <= ps[i] - 6'd1;
                    end
                end

                if (tmr_wr)
                    en[i] <= sfrDataIn[2*i+1];
                // Single-pass end-of-count stops the timer even if the same
                // edge carries a TMR write.
                if (eoc[i] && !pre[i][0])
                    en[i] <= 1'b0;

                irq_q[i] <= eoc[i];
            end
        end
    end

    // Register read mux; undecoded addresses return 0xFF and LD bits read 0.
    always_comb begin
        sfrDataOut = 8'hFF;
        case (sfrAddr)
            ADDR_TMR:  sfrDataOut = {tout_sel, tmr_spare, en[1], 1'b0, en[0], 1'b0};
            ADDR_T1:   sfrDataOut = cnt[1];
            ADDR_PRE1: sfrDataOut = pre[1];
            ADDR_T0:   sfrDataOut = cnt[0];
            ADDR_PRE0: sfrDataOut = pre[0];
            default:   sfrDataOut = 8'hFF;
        endcase
    end

`ifdef Z8_TIMER_TOUT_EN
    logic tout_q;

    // TOUT toggles on end-of-count of the selected timer, aligned with its irq.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tout_q <= 1'b0;
        else if (((tout_sel == 2'b01) && eoc[0]) || ((tout_sel == 2'b10) && eoc[1]))
            tout_q <= ~tout_q;
    end

    assign tout = tout_q;
`else
    assign tout = 1'b0;
`endif

endmodule
